// File: rtl/aula_20201105_qsys_nios2_qsys_oci_dct_pkg.sv
// Shared definitions for the OCI data-trace capture block.
// Contents:
//   - Default values for the block parameters.
//   - The capture FSM state encoding. It is exported on the `state` port so
//     that outside logic can observe the FSM.
package aula_20201105_qsys_nios2_qsys_oci_dct_pkg;

    localparam int DCT_W_DEFAULT  = 30;
    localparam int CNT_W_DEFAULT  = 4;
    localparam int DEPTH_DEFAULT  = 16;
    localparam int DROP_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } dct_state_e;

endpackage

// File: rtl/aula_20201105_qsys_nios2_qsys_oci_dct_fifo.sv
// Show-ahead FIFO that holds captured trace words.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   push, wr_data     write request and write word
//   pop               read request; it is ignored while the FIFO is empty
//   popped            a pop is taken at this edge (pop && !empty)
//   rd_data           head entry, read combinationally from storage
//   full, empty       occupancy flags
//   level             number of entries held (0..DEPTH)
// A push while full is taken only when a pop is taken in the same cycle.
// The read pointer changes only on a pop that is actually taken.
module aula_20201105_qsys_nios2_qsys_oci_dct_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic                     popped,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign popped  = do_pop;
    assign level   = cnt;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset. Stale contents are never visible, because
    // rd_data is meaningful only while the FIFO is not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/aula_20201105_qsys_nios2_qsys_oci_dct_capture.sv
// Captures data-trace words into a FIFO under control of a small FSM.
// FSM sequence: IDLE -> CAPTURE -> DRAIN -> DONE.
// Ports:
//   clk, reset_n               clock and asynchronous active-low reset
//   capture_en                 arm capture; when low, the FSM returns to IDLE
//   dct_valid, dct_buffer,
//   dct_count                  trace input; dct_count == 0 carries no data
//   test_ending                start draining
//   test_has_ended             abort straight to DONE
//   rd_en, rd_data, rd_empty   show-ahead read port
//   level                      FIFO occupancy
//   overflow, drop_cnt         sticky drop flag and saturating drop count
//   state, done                FSM observation
// Handshake:
//   Write side: there is no backpressure. A qualified word that finds the
//   FIFO full, with no pop in the same cycle, is dropped and counted.
//   Read side: rd_data is valid while rd_empty == 0. A pop happens at a
//   rising edge where rd_en == 1 and rd_empty == 0.
module aula_20201105_qsys_nios2_qsys_oci_dct_capture
    import aula_20201105_qsys_nios2_qsys_oci_dct_pkg::*;
#(
    parameter int DCT_W  = DCT_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DROP_W = DROP_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      capture_en,
    input  logic                      dct_valid,
    input  logic [DCT_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      rd_en,
    output logic [CNT_W+DCT_W-1:0]    rd_data,
    output logic                      rd_empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_cnt,
    output logic [1:0]                state,
    output logic                      done
);

    dct_state_e state_q;
    dct_state_e state_d;

    logic attempt;
    logic accept;
    logic drop;
    logic full;
    logic popped;
    logic drain_empty;
    logic arm;

    aula_20201105_qsys_nios2_qsys_oci_dct_fifo #(
        .W     (CNT_W + DCT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .wr_data ({dct_count, dct_buffer}),
        .pop     (rd_en),
        .popped  (popped),
        .rd_data (rd_data),
        .full    (full),
        .empty   (rd_empty),
        .level   (level)
    );

    assign attempt = (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
    assign accept  = attempt && (!full || popped);
    assign drop    = attempt && !accept;

    // No pushes occur in DRAIN. The FIFO is therefore empty after this edge
    // if it is empty now, or if it holds one entry and that entry is popped.
    assign drain_empty = (level == '0) || ((level == 1) && popped);

    // Moving from IDLE to CAPTURE starts a new capture session.
    assign arm = (state_q == ST_IDLE) && (state_d == ST_CAPTURE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: abort first, then disarm, then the normal sequence.
    always_comb begin
        state_d = state_q;
        if (test_has_ended) begin
            state_d = ST_DONE;
        end else if (!capture_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_CAPTURE;
                ST_CAPTURE: if (test_ending) state_d = ST_DRAIN;
                ST_DRAIN:   if (drain_empty) state_d = ST_DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (arm) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign state = state_q;
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_aula_20201105_qsys_nios2_qsys_oci_dct_capture.sv
module tb_aula_20201105_qsys_nios2_qsys_oci_dct_capture;

    localparam int DCT_W  = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 8;
    localparam int W      = CNT_W + DCT_W;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic              capture_en;
    logic              dct_valid;
    logic [DCT_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_ending;
    logic              test_has_ended;
    logic              rd_en;
    logic [W-1:0]      rd_data;
    logic              rd_empty;
    logic [4:0]        level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic [1:0]        state;
    logic              done;

    aula_20201105_qsys_nios2_qsys_oci_dct_capture #(
        .DCT_W  (DCT_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .capture_en     (capture_en),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .level          (level),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .state          (state),
        .done           (done)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop is taken at the next rising edge when rd_en && !rd_empty.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && rd_en === 1'b1 && rd_empty === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: rd_data=%0h, no entry expected", rd_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CNT_W-1:0] c, input logic [DCT_W-1:0] b,
                        input bit stored, input bit with_pop);
        dct_valid  = 1'b1;
        dct_count  = c;
        dct_buffer = b;
        rd_en      = with_pop;
        if (stored) exp_q.push_back({c, b});
        tick();
        dct_valid  = 1'b0;
        dct_count  = '0;
        rd_en      = 1'b0;
    endtask

    task automatic pops(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic rearm();
        capture_en = 1'b0;
        tick();
        capture_en = 1'b1;
        tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        capture_en     = 1'b0;
        dct_valid      = 1'b0;
        dct_buffer     = '0;
        dct_count      = '0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_en          = 1'b0;
        repeat (2) tick();

        // reset values
        check("rst_state", state, 0);
        check("rst_level", level, 0);
        check("rst_empty", rd_empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        tick();

        // basic capture of three words, read back in order
        capture_en = 1'b1;
        tick();
        check("arm_state", state, 1);
        push(4'd1, 30'h1, 1, 0);
        push(4'd1, 30'h2, 1, 0);
        push(4'd1, 30'h3, 1, 0);
        check("basic_level", level, 3);
        pops(3);
        check("basic_empty", rd_empty, 1);
        pops(1);  // pop while empty is a no-op
        check("empty_pop_level", level, 0);
        check("empty_pop_empty", rd_empty, 1);

        // 20 pushes into a 16-deep FIFO: the last 4 are dropped
        for (int i = 0; i < 20; i++) begin
            push(CNT_W'(1 + (i % 15)), DCT_W'(32'h100 + i), i < 16, 0);
        end
        check("ovf_level", level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 4);

        // push while full with a pop in the same cycle is accepted
        push(4'd9, 30'h200, 1, 1);
        check("full_pp_level", level, 16);
        check("full_pp_drop_cnt", drop_cnt, 4);
        // push while full with no pop is dropped
        push(4'd9, 30'h201, 0, 0);
        check("full_drop_cnt", drop_cnt, 5);
        pops(16);
        check("full_drain_empty", rd_empty, 1);

        // overflow is kept in IDLE and cleared when capture is re-armed
        capture_en = 1'b0;
        tick();
        check("idle_state", state, 0);
        check("idle_overflow_kept", overflow, 1);
        capture_en = 1'b1;
        tick();
        check("rearm_overflow", overflow, 0);
        check("rearm_drop_cnt", drop_cnt, 0);

        // drain sequence: 5 entries, then test_ending
        for (int i = 0; i < 5; i++) push(4'd2, DCT_W'(32'h50 + i), 1, 0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("drain_state", state, 2);
        push(4'd3, 30'h3ff, 0, 0);  // ignored in DRAIN
        check("drain_ignore_level", level, 5);
        check("drain_ignore_drop", drop_cnt, 0);
        pops(4);
        check("drain_mid_state", state, 2);
        pops(1);
        check("drain_done_state", state, 3);
        check("drain_done", done, 1);
        check("drain_level", level, 0);

        // count==0 is never stored; abort has priority over test_ending
        rearm();
        push(4'd0, 30'h777, 0, 0);
        check("cnt0_level", level, 0);
        check("cnt0_drop", drop_cnt, 0);
        test_ending    = 1'b1;
        test_has_ended = 1'b1;
        tick();
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        check("abort_state", state, 3);
        check("abort_done", done, 1);

        // asynchronous reset in the middle of DRAIN
        rearm();
        for (int i = 0; i < 7; i++) push(4'd4, DCT_W'(32'h300 + i), 1, 0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("pre_rst_state", state, 2);
        check("pre_rst_level", level, 7);
        #2;
        reset_n = 1'b0;
        #1;  // still between clock edges
        check("async_state", state, 0);
        check("async_level", level, 0);
        check("async_empty", rd_empty, 1);
        check("async_done", done, 0);
        check("async_drop_cnt", drop_cnt, 0);
        exp_q.delete();  // the reset discards the captured entries
        tick();
        reset_n = 1'b1;
        capture_en = 1'b0;
        pops(1);
        check("post_rst_level", level, 0);
        check("post_rst_state", state, 0);

        check("scoreboard_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aula_20201105_qsys_nios2_qsys_oci_dct_capture.md
AULA_20201105_QSYS_NIOS2_QSYS_OCI_DCT_CAPTURE -- requirements
Module: aula_20201105_qsys_nios2_qsys_oci_dct_capture

Interface
REQ-001 The block SHALL have parameter DCT_W, default 30, meaning the data-trace word width.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the trace count field width.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the FIFO entries, power of 2, minimum 2.
REQ-004 The block SHALL have parameter DROP_W, default 8, meaning the drop counter width.
REQ-005 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  capture_en  in  1  arm capture; low returns to IDLE
  dct_valid  in  1  dct_buffer/dct_count qualify this cycle
  dct_buffer  in  DCT_W  trace payload
  dct_count  in  CNT_W  valid entries in payload; 0 = nothing to store
  test_ending  in  1  begin drain
  test_has_ended  in  1  abort, go straight to DONE
  rd_en  in  1  pop one entry (ignored when rd_empty)
  rd_data  out  CNT_W+DCT_W  {count,buffer} at head, show-ahead
  rd_empty  out  1  FIFO empty
  level  out  clog2(DEPTH)+1  entries held
  overflow  out  1  sticky: an entry was dropped
  drop_cnt  out  DROP_W  dropped entries, saturating
  state  out  2  current FSM state
  done  out  1  high in DONE

Function
REQ-006 FSM states SHALL be IDLE=0, CAPTURE=1, DRAIN=2, DONE=3, registered.
REQ-007 IDLE→CAPTURE SHALL occur when capture_en=1 at the clock edge.
REQ-008 CAPTURE→DRAIN SHALL occur when test_ending=1.
REQ-009 DRAIN→DONE SHALL occur on the edge where level becomes 0 or is already 0.
REQ-010 test_has_ended=1 SHALL force DONE from any state; this has priority over test_ending.
REQ-011 capture_en=0 SHALL force IDLE from CAPTURE, DRAIN or DONE, with priority below test_has_ended; FIFO contents are retained.
REQ-012 A write attempt SHALL be state==CAPTURE && dct_valid && dct_count!=0; writes in all other states or cases SHALL be ignored without counting.
REQ-013 An attempt SHALL be accepted if !full, or if full with a same-cycle effective pop.
REQ-014 An attempt that is not accepted SHALL set overflow and increment drop_cnt, which saturates at all-ones.
REQ-015 Pops SHALL be honoured in every state when !rd_empty; a pop while empty SHALL be a no-op with no pointer change.
REQ-016 A simultaneous push and pop SHALL leave level unchanged.
REQ-017 Pointers SHALL wrap modulo DEPTH; full SHALL be level==DEPTH.
REQ-018 rd_data SHALL show the head entry combinationally from storage and is undefined when rd_empty=1.
REQ-019 An entry written at edge N SHALL be visible on rd_data/rd_empty after edge N (1-cycle latency).
REQ-020 overflow and drop_cnt SHALL clear only on reset or on the IDLE→CAPTURE transition.
REQ-021 done SHALL equal (state==DONE).

Reset
REQ-022 On reset_n=0, asynchronously: state=IDLE, pointers=0, level=0, rd_empty=1, overflow=0, drop_cnt=0, done=0.
REQ-023 Reset SHALL abort a drain with no further pop or push; storage contents need not be cleared.

Structure
REQ-024 The package aula_20201105_qsys_nios2_qsys_oci_dct_pkg SHALL hold the state enum and parameter defaults.
REQ-025 Storage and pointers SHALL live in the sub-module aula_20201105_qsys_nios2_qsys_oci_dct_fifo (push, pop, full, empty, level).
REQ-026 The FSM, accept logic and drop counter SHALL live in the top module.

Verification
REQ-027 Reset, capture_en=1, 3 pushes of buffer 0x1,0x2,0x3 with count 1 → level=3; pops return {1,0x1},{1,0x2},{1,0x3} in order; rd_empty=1 afterwards.
REQ-028 DEPTH=16: 20 pushes with no pops → level=16, overflow=1, drop_cnt=4; the first 16 entries are intact.
REQ-029 At full, push with same-cycle pop → accepted; level stays 16; drop_cnt unchanged.
REQ-030 With 5 entries, test_ending pulse → DRAIN; pushes ignored; after 5 pops → DONE, done=1.
REQ-031 test_ending and test_has_ended in the same cycle → DONE next edge; a push with dct_count=0 is never stored.
REQ-032 reset_n low mid-DRAIN with level 7 → outputs reach their reset values immediately, without waiting for clk.
